chip8_sprite_engine: RTL and testbench



---
 rtl/chip8_sprite_engine_if.sv | 46 ++++
 rtl/chip8_sprite_engine.sv | 158 +++++++++++++++
 tb/tb_chip8_sprite_engine.sv | 319 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/chip8_sprite_engine_if.sv
// Bundles the draw command, sprite-memory read port, framebuffer row port and
// status of the CHIP-8 sprite engine; master is the engine, slave is the core.
interface chip8_sprite_engine_if #(
  parameter int DISP_W = 64,
  parameter int DISP_H = 32,
  parameter int ADDR_W = 12
);
  localparam int YW = $clog2(DISP_H);

  logic              start;
  logic [7:0]        x;
  logic [7:0]        y;
  logic [3:0]        n;
  logic [ADDR_W-1:0] base_addr;
  logic              wrap_mode;
  logic              hires16;

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd_en;
  logic [7:0]        mem_rdata;

  logic [YW-1:0]     fb_row_addr;
  logic              fb_rd_en;
  logic [DISP_W-1:0] fb_row_rdata;
  logic              fb_we;
  logic [DISP_W-1:0] fb_row_wdata;

  logic              busy;
  logic              done;
  logic [7:0]        vf;
  logic [4:0]        collision_rows;

  modport master (
    input  start, x, y, n, base_addr, wrap_mode, hires16,
    input  mem_rdata, fb_row_rdata,
    output mem_addr, mem_rd_en, fb_row_addr, fb_rd_en, fb_we, fb_row_wdata,
    output busy, done, vf, collision_rows
  );

  modport slave (
    output start, x, y, n, base_addr, wrap_mode, hires16,
    output mem_rdata, fb_row_rdata,
    input  mem_addr, mem_rd_en, fb_row_addr, fb_rd_en, fb_we, fb_row_wdata,
    input  busy, done, vf, collision_rows
  );
endinterface

// File: rtl/chip8_sprite_engine.sv
// Multi-cycle DXYN / DXY0 sprite draw: fetches sprite bytes, read-modify-writes
// one framebuffer row per sprite line with XOR and collision reporting.
module chip8_sprite_engine #(
  parameter int DISP_W = 64,
  parameter int DISP_H = 32,
  parameter int ADDR_W = 12
) (
  input logic                   instruction_clk,
  input logic                   rst,
  chip8_sprite_engine_if.master bus
);
  localparam int XW = $clog2(DISP_W);
  localparam int YW = $clog2(DISP_H);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH0 = 3'd1;
  localparam logic [2:0] S_FETCH1 = 3'd2;
  localparam logic [2:0] S_MERGE  = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  logic [2:0]        r_state;
  logic [XW-1:0]     r_x;
  logic [YW-1:0]     r_y;
  logic [ADDR_W-1:0] r_base;
  logic              r_wrap;
  logic              r_wide;
  logic [4:0]        r_rows;
  logic [4:0]        r_row;
  logic [7:0]        r_hi;
  logic [DISP_W-1:0] r_old;
  logic              r_coll;
  logic [4:0]        r_coll_rows;

  logic              w_wide;
  logic [4:0]        w_rows;
  logic [5:0]        w_row_off;
  logic [ADDR_W-1:0] w_line_addr;
  logic [YW-1:0]     w_fb_row;
  logic [15:0]       w_sprite;
  logic [DISP_W-1:0] w_top;
  logic [2*DISP_W-1:0] w_dbl;
  logic [DISP_W-1:0] w_line;
  logic [DISP_W-1:0] w_old;
  logic              w_hit;
  logic [4:0]        w_next_row;
  logic [7:0]        w_next_abs;
  logic              w_clip_next;
  logic              w_last;
  logic              w_unused;

  assign w_wide      = bus.hires16 && (bus.n == 4'd0);
  assign w_rows      = w_wide ? 5'd16 : {1'b0, bus.n};
  assign w_row_off   = r_wide ? {r_row, 1'b0} : {1'b0, r_row};
  assign w_line_addr = r_base + ADDR_W'(w_row_off);
  assign w_fb_row    = r_y + YW'(r_row);

  // Sprite line left-aligned at column 0, then moved to column x; the doubled
  // vector turns the right shift into a rotate for wrap mode.
  assign w_sprite = r_wide ? {r_hi, bus.mem_rdata} : {bus.mem_rdata, 8'h00};
  assign w_top    = {w_sprite, {(DISP_W-16){1'b0}}};
  assign w_dbl    = {w_top, w_top} >> r_x;
  assign w_line   = r_wrap ? w_dbl[DISP_W-1:0] : (w_top >> r_x);

  // 16-wide lines spend an extra cycle fetching, so the old row was captured.
  assign w_old = r_wide ? r_old : bus.fb_row_rdata;
  assign w_hit = |(w_old & w_line);

  assign w_next_row  = r_row + 5'd1;
  assign w_next_abs  = 8'(r_y) + {3'b000, w_next_row};
  assign w_clip_next = !r_wrap && (w_next_abs >= 8'(DISP_H));
  assign w_last      = (w_next_row == r_rows) || w_clip_next;

  assign w_unused = ^{bus.x[7:XW], bus.y[7:YW]};

  always_ff @(posedge instruction_clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_x         <= '0;
      r_y         <= '0;
      r_base      <= '0;
      r_wrap      <= 1'b0;
      r_wide      <= 1'b0;
      r_rows      <= '0;
      r_row       <= '0;
      r_hi        <= '0;
      r_old       <= '0;
      r_coll      <= 1'b0;
      r_coll_rows <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_x         <= bus.x[XW-1:0];
            r_y         <= bus.y[YW-1:0];
            r_base      <= bus.base_addr;
            r_wrap      <= bus.wrap_mode;
            r_wide      <= w_wide;
            r_rows      <= w_rows;
            r_row       <= '0;
            r_coll      <= 1'b0;
            r_coll_rows <= '0;
            r_state     <= (w_rows == 5'd0) ? S_DONE : S_FETCH0;
          end
        end
        S_FETCH0: r_state <= r_wide ? S_FETCH1 : S_MERGE;
        S_FETCH1: begin
          r_hi    <= bus.mem_rdata;
          r_old   <= bus.fb_row_rdata;
          r_state <= S_MERGE;
        end
        S_MERGE: begin
          if (w_hit) begin
            r_coll      <= 1'b1;
            r_coll_rows <= r_coll_rows + 5'd1;
          end
          r_row   <= w_next_row;
          r_state <= w_last ? S_DONE : S_FETCH0;
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    bus.mem_addr     = '0;
    bus.mem_rd_en    = 1'b0;
    bus.fb_row_addr  = '0;
    bus.fb_rd_en     = 1'b0;
    bus.fb_we        = 1'b0;
    bus.fb_row_wdata = '0;
    bus.done         = 1'b0;
    case (r_state)
      S_FETCH0: begin
        bus.mem_addr    = w_line_addr;
        bus.mem_rd_en   = 1'b1;
        bus.fb_row_addr = w_fb_row;
        bus.fb_rd_en    = 1'b1;
      end
      S_FETCH1: begin
        bus.mem_addr  = w_line_addr + ADDR_W'(1);
        bus.mem_rd_en = 1'b1;
      end
      S_MERGE: begin
        bus.fb_row_addr  = w_fb_row;
        bus.fb_we        = 1'b1;
        bus.fb_row_wdata = w_old ^ w_line;
      end
      S_DONE:  bus.done = 1'b1;
      default: ;
    endcase
  end

  assign bus.busy           = (r_state == S_FETCH0) || (r_state == S_FETCH1) ||
                              (r_state == S_MERGE);
  assign bus.vf             = {7'b0000000, r_coll};
  assign bus.collision_rows = r_coll_rows;
endmodule

// File: tb/tb_chip8_sprite_engine.sv
// Drives a 64x32 and a 128x64 sprite engine with table vectors, corner-case
// sequences and random draws, checked against a pixel-level reference model.
module tb_chip8_sprite_engine;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clr_req = 1'b0;
  always #5 clk = ~clk;

  chip8_sprite_engine_if #(.DISP_W(64),  .DISP_H(32), .ADDR_W(12)) is_if ();
  chip8_sprite_engine_if #(.DISP_W(128), .DISP_H(64), .ADDR_W(12)) ib_if ();

  chip8_sprite_engine #(.DISP_W(64), .DISP_H(32), .ADDR_W(12)) dut_s (
    .instruction_clk(clk), .rst(rst), .bus(is_if));
  chip8_sprite_engine #(.DISP_W(128), .DISP_H(64), .ADDR_W(12)) dut_b (
    .instruction_clk(clk), .rst(rst), .bus(ib_if));

  logic [7:0]   pmem  [0:4095];
  logic [63:0]  fb_s  [0:31];
  logic [127:0] fb_b  [0:63];
  logic [127:0] mfb   [0:1][0:63];

  // Memory and framebuffer models with one-cycle registered reads.
  always @(posedge clk) begin
    if (clr_req) begin
      for (int r = 0; r < 32; r++) fb_s[r] <= '0;
      for (int r = 0; r < 64; r++) fb_b[r] <= '0;
    end else begin
      if (is_if.fb_we) fb_s[is_if.fb_row_addr] <= is_if.fb_row_wdata;
      if (ib_if.fb_we) fb_b[ib_if.fb_row_addr] <= ib_if.fb_row_wdata;
    end
    if (is_if.fb_rd_en)  is_if.fb_row_rdata <= fb_s[is_if.fb_row_addr];
    if (ib_if.fb_rd_en)  ib_if.fb_row_rdata <= fb_b[ib_if.fb_row_addr];
    if (is_if.mem_rd_en) is_if.mem_rdata    <= pmem[is_if.mem_addr];
    if (ib_if.mem_rd_en) ib_if.mem_rdata    <= pmem[ib_if.mem_addr];
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_all();
    clr_req = 1'b1;
    @(posedge clk);
    #1 clr_req = 1'b0;
    for (int b = 0; b < 2; b++)
      for (int r = 0; r < 64; r++) mfb[b][r] = '0;
  endtask

  task automatic set_start(input bit big, input logic v);
    if (big) ib_if.start = v;
    else     is_if.start = v;
  endtask

  task automatic drive_cmd(input logic [7:0] x, y, input logic [3:0] n,
                           input logic [11:0] base, input bit wrap, hires);
    is_if.x = x; is_if.y = y; is_if.n = n; is_if.base_addr = base;
    is_if.wrap_mode = wrap; is_if.hires16 = hires;
    ib_if.x = x; ib_if.y = y; ib_if.n = n; ib_if.base_addr = base;
    ib_if.wrap_mode = wrap; ib_if.hires16 = hires;
  endtask

  // Reference: applies the draw pixel by pixel to the model framebuffer.
  task automatic model_draw(input bit big, input logic [7:0] x, y, input logic [3:0] n,
                            input logic [11:0] base, input bit wrap, hires,
                            output int drawn, output int crows);
    int w, h, rows, sw, x0, y0, yy, xx, bi;
    bit wide, hit;
    logic [7:0] b;
    logic [11:0] a;
    bi = big ? 1 : 0;
    w = big ? 128 : 64;
    h = big ? 64 : 32;
    wide = hires && (n == 4'd0);
    rows = wide ? 16 : int'(n);
    sw = wide ? 16 : 8;
    x0 = int'(x) % w;
    y0 = int'(y) % h;
    drawn = 0;
    crows = 0;
    for (int r = 0; r < rows; r++) begin
      yy = y0 + r;
      if (yy >= h) begin
        if (!wrap) break;
        yy -= h;
      end
      hit = 1'b0;
      for (int c = 0; c < sw; c++) begin
        a = wide ? base + 12'(2 * r + c / 8) : base + 12'(r);
        b = pmem[a];
        if (b[7 - c % 8]) begin
          xx = x0 + c;
          if (xx >= w) begin
            if (!wrap) continue;
            xx -= w;
          end
          if (mfb[bi][yy][w - 1 - xx]) hit = 1'b1;
          mfb[bi][yy][w - 1 - xx] = ~mfb[bi][yy][w - 1 - xx];
        end
      end
      drawn++;
      if (hit) crows++;
    end
  endtask

  function automatic logic [127:0] dut_row(input bit big, input int r);
    return big ? fb_b[r] : {64'd0, fb_s[r]};
  endfunction

  // One draw: start at edge 0, watch until done, compare against the model.
  task automatic run_draw(input bit big, input logic [7:0] x, y, input logic [3:0] n,
                          input logic [11:0] base, input bit wrap, hires,
                          input int inj_k, input bit inj_done,
                          output int cycles, output int we_cnt,
                          output logic [7:0] vf_o, output logic [4:0] cr_o);
    logic [11:0] addrs[$];
    logic [11:0] exp_addrs[$];
    int drawn, crows, exp_cyc, errs, bad_rows, h;
    bit wide, s_done, s_we, s_rd, s_busy;
    cycles = -1;
    we_cnt = 0;
    vf_o = '0;
    cr_o = '0;
    @(posedge clk);
    #1;
    drive_cmd(x, y, n, base, wrap, hires);
    set_start(big, 1'b1);
    @(posedge clk);
    #1 set_start(big, 1'b0);
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      s_done = big ? ib_if.done : is_if.done;
      s_we   = big ? ib_if.fb_we : is_if.fb_we;
      s_rd   = big ? ib_if.mem_rd_en : is_if.mem_rd_en;
      s_busy = big ? ib_if.busy : is_if.busy;
      if (s_we) we_cnt++;
      if (s_rd) addrs.push_back(big ? ib_if.mem_addr : is_if.mem_addr);
      if (k == inj_k)     set_start(big, 1'b1);
      if (k == inj_k + 1) set_start(big, 1'b0);
      if (s_done) begin
        cycles = k;
        vf_o = big ? ib_if.vf : is_if.vf;
        cr_o = big ? ib_if.collision_rows : is_if.collision_rows;
        chk("busy_low_at_done", {127'd0, s_busy}, 128'd0);
        if (inj_done) set_start(big, 1'b1);
        break;
      end
    end
    if (cycles < 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL done_timeout: got no done pulse, expected one within 200 cycles");
    end
    @(posedge clk);
    #1 set_start(big, 1'b0);

    model_draw(big, x, y, n, base, wrap, hires, drawn, crows);
    wide = hires && (n == 4'd0);
    exp_cyc = (!wide && n == 4'd0) ? 1 : (wide ? 3 : 2) * drawn + 1;
    for (int r = 0; r < drawn; r++) begin
      if (wide) begin
        exp_addrs.push_back(base + 12'(2 * r));
        exp_addrs.push_back(base + 12'(2 * r + 1));
      end else begin
        exp_addrs.push_back(base + 12'(r));
      end
    end
    errs = (addrs.size() == exp_addrs.size()) ? 0 : 1;
    if (errs == 0)
      for (int i = 0; i < addrs.size(); i++) if (addrs[i] !== exp_addrs[i]) errs++;
    h = big ? 64 : 32;
    bad_rows = 0;
    for (int r = 0; r < h; r++) if (dut_row(big, r) !== mfb[big ? 1 : 0][r]) bad_rows++;

    chk("model_latency", cycles, exp_cyc);
    chk("model_we_count", we_cnt, drawn);
    chk("model_vf", vf_o, (crows != 0) ? 1 : 0);
    chk("model_collision_rows", cr_o, crows);
    chk("model_mem_addr_seq_errors", errs, 0);
    chk("model_fb_rows_differing", bad_rows, 0);
    $display("draw big=%0d x=%0d y=%0d n=%0d I=%03h wrap=%0d hires=%0d: cycles=%0d we=%0d vf=%0d crows=%0d",
             big, x, y, n, base, wrap, hires, cycles, we_cnt, vf_o, cr_o);
  endtask

  typedef struct {
    bit           clr;
    bit           big;
    logic [7:0]   x;
    logic [7:0]   y;
    logic [3:0]   n;
    logic [11:0]  base;
    bit           wrap;
    bit           hires;
    int           exp_cyc;
    int           exp_we;
    logic [7:0]   exp_vf;
    logic [4:0]   exp_cr;
    int           chk_row;
    logic [127:0] chk_val;
  } vec_t;

  vec_t vecs[11];

  initial begin
    int cyc, we, extra_done, cnt;
    logic [7:0] vf_v;
    logic [4:0] cr_v;

    vecs[0]  = '{1, 0, 8'd0,  8'd0,  4'd5, 12'h050, 1, 0, 11, 5, 8'd0, 5'd0,  0,  128'h0000_0000_0000_0000_F000_0000_0000_0000};
    vecs[1]  = '{0, 0, 8'd0,  8'd0,  4'd5, 12'h050, 1, 0, 11, 5, 8'd1, 5'd5,  2,  128'h0};
    vecs[2]  = '{1, 0, 8'd60, 8'd3,  4'd1, 12'h100, 1, 0, 3,  1, 8'd0, 5'd0,  3,  128'h0000_0000_0000_0000_F000_0000_0000_000F};
    vecs[3]  = '{1, 0, 8'd60, 8'd3,  4'd1, 12'h100, 0, 0, 3,  1, 8'd0, 5'd0,  3,  128'h0000_0000_0000_0000_0000_0000_0000_000F};
    vecs[4]  = '{1, 0, 8'd8,  8'd30, 4'd4, 12'h200, 0, 0, 5,  2, 8'd0, 5'd0,  0,  128'h0};
    vecs[5]  = '{1, 0, 8'd8,  8'd30, 4'd4, 12'h200, 1, 0, 9,  4, 8'd0, 5'd0,  1,  128'h0000_0000_0000_0000_0018_0000_0000_0000};
    vecs[6]  = '{1, 1, 8'd16, 8'd8,  4'd0, 12'h300, 1, 1, 49, 16, 8'd0, 5'd0, 8,  128'h0000_FFFF_0000_0000_0000_0000_0000_0000};
    vecs[7]  = '{0, 1, 8'd16, 8'd8,  4'd0, 12'h300, 1, 0, 1,  0, 8'd0, 5'd0,  8,  128'h0000_FFFF_0000_0000_0000_0000_0000_0000};
    vecs[8]  = '{0, 1, 8'd16, 8'd8,  4'd0, 12'h300, 1, 1, 49, 16, 8'd1, 5'd16, 8, 128'h0};
    vecs[9]  = '{1, 0, 8'd56, 8'd20, 4'd0, 12'h300, 0, 1, 37, 12, 8'd0, 5'd0, 20, 128'h0000_0000_0000_0000_0000_0000_0000_00FF};
    vecs[10] = '{0, 0, 8'd60, 8'd20, 4'd1, 12'h100, 1, 0, 3,  1, 8'd1, 5'd1,  20, 128'h0000_0000_0000_0000_F000_0000_0000_00F0};

    for (int i = 0; i < 4096; i++) pmem[i] = 8'($urandom);
    pmem[12'h050] = 8'hF0; pmem[12'h051] = 8'h90; pmem[12'h052] = 8'h90;
    pmem[12'h053] = 8'h90; pmem[12'h054] = 8'hF0;
    pmem[12'h100] = 8'hFF;
    pmem[12'h200] = 8'h81; pmem[12'h201] = 8'h42; pmem[12'h202] = 8'h24; pmem[12'h203] = 8'h18;
    for (int i = 0; i < 32; i++) pmem[12'h300 + i] = 8'hFF;

    is_if.start = 1'b0;
    ib_if.start = 1'b0;
    drive_cmd(8'd0, 8'd0, 4'd0, 12'h000, 1'b0, 1'b0);

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_busy",      {127'd0, is_if.busy},      128'd0);
    chk("reset_done",      {127'd0, is_if.done},      128'd0);
    chk("reset_vf",        is_if.vf,                  128'd0);
    chk("reset_crows",     is_if.collision_rows,      128'd0);
    chk("reset_fb_we",     {127'd0, is_if.fb_we},     128'd0);
    chk("reset_mem_rd_en", {127'd0, is_if.mem_rd_en}, 128'd0);
    chk("reset_big_busy",  {127'd0, ib_if.busy},      128'd0);
    chk("reset_big_vf",    ib_if.vf,                  128'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < 11; i++) begin
      if (vecs[i].clr) clear_all();
      run_draw(vecs[i].big, vecs[i].x, vecs[i].y, vecs[i].n, vecs[i].base,
               vecs[i].wrap, vecs[i].hires, -10, 1'b0, cyc, we, vf_v, cr_v);
      chk($sformatf("vec%0d_latency", i), cyc, vecs[i].exp_cyc);
      chk($sformatf("vec%0d_we_count", i), we, vecs[i].exp_we);
      chk($sformatf("vec%0d_vf", i), vf_v, vecs[i].exp_vf);
      chk($sformatf("vec%0d_collision_rows", i), cr_v, vecs[i].exp_cr);
      chk($sformatf("vec%0d_row%0d", i, vecs[i].chk_row),
          dut_row(vecs[i].big, vecs[i].chk_row), vecs[i].chk_val);
    end

    // Starts while busy and during DONE must both be dropped.
    clear_all();
    run_draw(1'b0, 8'd0, 8'd0, 4'd5, 12'h050, 1'b1, 1'b0, 3, 1'b1, cyc, we, vf_v, cr_v);
    chk("busy_start_latency", cyc, 11);
    chk("busy_start_we_count", we, 5);
    extra_done = 0;
    cnt = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (is_if.done) extra_done++;
      if (is_if.busy) cnt++;
    end
    chk("busy_start_extra_done", extra_done, 0);
    chk("busy_start_extra_busy", cnt, 0);
    $display("overlap starts: extra done=%0d busy cycles=%0d", extra_done, cnt);

    // Reset asserted mid-draw aborts it.
    clear_all();
    @(posedge clk);
    #1;
    drive_cmd(8'd0, 8'd0, 4'd5, 12'h050, 1'b1, 1'b0);
    is_if.start = 1'b1;
    @(posedge clk);
    #1 is_if.start = 1'b0;
    for (int k = 1; k <= 5; k++) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midreset_busy", {127'd0, is_if.busy}, 128'd0);
    chk("midreset_done", {127'd0, is_if.done}, 128'd0);
    chk("midreset_vf",   is_if.vf,             128'd0);
    cnt = 0;
    extra_done = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (is_if.fb_we) cnt++;
      if (is_if.done) extra_done++;
      if (k == 1) rst = 1'b0;
    end
    chk("midreset_fb_we", cnt, 0);
    chk("midreset_no_done", extra_done, 0);
    chk("midreset_row0_kept", dut_row(1'b0, 0), 128'h0000_0000_0000_0000_F000_0000_0000_0000);
    $display("mid-draw reset: fb_we after reset=%0d done=%0d", cnt, extra_done);

    clear_all();
    for (int t = 0; t < 24; t++) begin
      bit big_r;
      big_r = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) clear_all();
      run_draw(big_r, 8'($urandom), 8'($urandom), 4'($urandom),
               12'($urandom_range(12'h400, 12'hFFF)), 1'($urandom), 1'($urandom),
               -10, 1'b0, cyc, we, vf_v, cr_v);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
